// File: rtl/vga_pkg.sv
// Shared VGA timing constants (XGA 1024x768 @ 60 Hz) and decode helpers.
// Used by the timing generator and by the downstream drawing stages.
package vga_pkg;

    localparam int CW = 11;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 160;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 768;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 29;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Half-open window test: lo <= c < hi
    function automatic logic in_window(input logic [CW-1:0] c,
                                       input logic [CW-1:0] lo,
                                       input logic [CW-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-N up-counter with enable; exposes the next count so callers can
// decode flags that line up with the registered count.
module vga_counter #(
    parameter int N = 1344,
    parameter int W = 11
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Terminal compare happens before the increment so count never reaches N.
    always_comb begin
        wrap       = (count == LAST);
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync and blank flags, frame pulse
// and frame counter. Every output is a flop.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          en,
    output logic [10:0]   hcount_out,
    output logic [10:0]   vcount_out,
    output logic          hsync_out,
    output logic          hblnk_out,
    output logic          vsync_out,
    output logic          vblnk_out,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HSS = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HSE = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] HT  = CW'(H_TOTAL);
    localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VSS = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VSE = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] VT  = CW'(V_TOTAL);

    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          v_en;
    logic          frame_wrap;

    assign v_en       = en & h_wrap;
    assign frame_wrap = en & h_wrap & v_wrap;

    vga_counter #(.N(H_TOTAL), .W(CW)) u_hcnt (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .count      (hcount_out),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_counter #(.N(V_TOTAL), .W(CW)) u_vcnt (
        .pclk       (pclk),
        .rst        (rst),
        .en         (v_en),
        .count      (vcount_out),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Flags decode the next counts so they land in the same cycle as the counts.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hblnk_out <= 1'b0;
            hsync_out <= 1'b0;
            vblnk_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hblnk_out <= in_window(h_next, HA, HT);
            hsync_out <= in_window(h_next, HSS, HSE);
            vblnk_out <= in_window(v_next, VA, VT);
            vsync_out <= in_window(v_next, VSS, VSE);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pclk  in  1  pixel clock, 65 MHz nominal; the only clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; low freezes all state
- hcount_out  out  11  pixel column, 0..H_TOTAL-1
- vcount_out  out  11  line number, 0..V_TOTAL-1
- hsync_out  out  1  high during the horizontal sync window
- hblnk_out  out  1  high outside the visible columns
- vsync_out  out  1  high during the vertical sync window
- vblnk_out  out  1  high outside the visible lines
- frame_start  out  1  one-cycle pulse when (hcount,vcount) becomes (0,0)
- frame_cnt  out  16  count of completed frames

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (1344 by default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (806 by default).
REQ-004 While en=1, hcount_out SHALL increment by 1 on every pclk edge and wrap from H_TOTAL-1 to 0.
REQ-005 vcount_out SHALL increment only on the hcount wrap, and SHALL wrap from V_TOTAL-1 to 0 on the hcount wrap of the last line.
REQ-006 hblnk_out SHALL be 1 if and only if hcount_out >= H_ACTIVE (1024..1343).
REQ-007 hsync_out SHALL be 1 if and only if H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (1048..1183).
REQ-008 vblnk_out SHALL be 1 if and only if vcount_out >= V_ACTIVE (768..805).
REQ-009 vsync_out SHALL be 1 if and only if V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (771..776).
REQ-010 All outputs SHALL be registered, and each flag SHALL be decoded from the next-state counts so that it is cycle-aligned with the count value it describes (zero relative latency).
REQ-011 frame_start SHALL be 1 for exactly one cycle, in the cycle where the outputs show (0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
REQ-012 frame_start SHALL NOT fire on the first cycle after reset release.
REQ-013 frame_cnt SHALL increment in the same cycle as frame_start and wrap from 0xFFFF to 0.
REQ-014 While en=0, counts, flags and frame_cnt SHALL hold their values, and frame_start SHALL be 0.
REQ-015 When en returns to 1, counting SHALL resume from the held position with no skipped or repeated count.
REQ-016 All counter arithmetic SHALL be done at 11 bits, with the wrap comparison made before the increment so that no count >= TOTAL ever appears.

Reset
REQ-017 While rst=1, all outputs SHALL be 0 asynchronously; in particular hcount_out=0, vcount_out=0 and frame_cnt=0.
REQ-018 The first enabled pclk edge after rst deasserts SHALL produce hcount_out=1, vcount_out=0.
REQ-019 A reset mid-frame SHALL abandon the frame, and frame_cnt SHALL NOT count the abandoned frame.

Structure
REQ-020 The default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in a shared package, vga_pkg, which the downstream drawing stages also use.
REQ-021 The block SHALL instantiate one sub-module, vga_counter (a parameterised modulo-N counter with enable, wrap output and async active-high reset), once for horizontal and once for vertical; the vertical instance's enable is the horizontal wrap ANDed with en.

Verification
REQ-022 Reset then 1344 enabled cycles -> hcount returns to 0 and vcount=1; hsync high for exactly 136 cycles starting at hcount=1048; hblnk high for 320 cycles.
REQ-023 Run one full frame of 1344*806 cycles -> frame_start pulses once when (0,0) reappears; frame_cnt=1; vsync high on lines 771..776 only; vblnk high on lines 768..805.
REQ-024 Deassert en at hcount=1343, vcount=805 for 10 cycles -> outputs frozen and no frame_start; re-enable -> the next cycle shows (0,0), frame_start=1 and frame_cnt increments.
REQ-025 Assert rst asynchronously mid-line at hcount=500, vcount=300 -> all outputs go to 0 without waiting for a clock edge; after release the sequence restarts at hcount=1; frame_cnt=0.
REQ-026 Preload frame_cnt to 0xFFFF via a force and complete a frame -> frame_cnt=0x0000 with frame_start=1.
REQ-027 Every cycle, a checker SHALL assert: hcount<1344, vcount<806, and all flags match the REQ-006..REQ-009 decodes of the same-cycle counts.
